// File: rtl/sprite_pkg.sv
// Shared constants, index type and flat-vector slice helpers for the sprite compositor.
package sprite_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned MAX_SPR = 16;
    localparam int unsigned MAX_AW  = 16;

    localparam logic [7:0] TRANSPARENT = 8'hFF;
    localparam logic [7:0] BG_COLOR    = 8'h00;

    // Wide enough for any legal slot count (2..16).
    typedef logic [$clog2(MAX_SPR)-1:0] spr_idx_t;

    function automatic logic [COORD_W-1:0] get_x(input logic [MAX_SPR*COORD_W-1:0] flat,
                                                 input int unsigned i);
        return COORD_W'(flat >> (i * COORD_W));
    endfunction

    function automatic logic [MAX_AW-1:0] get_base(input logic [MAX_SPR*MAX_AW-1:0] flat,
                                                   input int unsigned i,
                                                   input int unsigned aw);
        return MAX_AW'(flat >> (i * aw));
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel-stream and shared-ROM bus between the video timing side and the compositor.
interface sprite_compositor_if
    import sprite_pkg::*;
#(
    parameter int unsigned ADDR_W = 13
) ();

    logic [COORD_W-1:0] x_ptr;
    logic [COORD_W-1:0] y_ptr;
    logic               pix_valid;
    logic               frame_start;
    logic [ADDR_W-1:0]  rom_addr;
    logic [7:0]         rom_data;
    logic [7:0]         RGB;
    logic               rgb_valid;

    modport master (
        output x_ptr, y_ptr, pix_valid, frame_start, rom_data,
        input  rom_addr, RGB, rgb_valid
    );

    modport slave (
        input  x_ptr, y_ptr, pix_valid, frame_start, rom_data,
        output rom_addr, RGB, rgb_valid
    );

endinterface

// File: rtl/sprite_hit_unit.sv
// Per-slot bounds test and ROM offset for the current pixel.
module sprite_hit_unit
    import sprite_pkg::*;
#(
    parameter int unsigned ADDR_W = 13
) (
    input  logic               en,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] x_ptr,
    input  logic [COORD_W-1:0] y_ptr,
    input  logic [COORD_W-1:0] spr_x,
    input  logic [COORD_W-1:0] spr_y,
    input  logic [COORD_W-1:0] spr_w,
    input  logic [COORD_W-1:0] spr_h,
    input  logic [ADDR_W-1:0]  base,
    output logic               hit,
    output logic [ADDR_W-1:0]  addr
);

    logic [COORD_W:0]   x_end;
    logic [COORD_W:0]   y_end;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;

    // One extra bit so a sprite hanging past the screen edge never wraps to column 0.
    assign x_end = {1'b0, spr_x} + {1'b0, spr_w};
    assign y_end = {1'b0, spr_y} + {1'b0, spr_h};

    assign hit = en && pix_valid
              && (x_ptr >= spr_x) && ({1'b0, x_ptr} < x_end)
              && (y_ptr >= spr_y) && ({1'b0, y_ptr} < y_end);

    assign dx   = x_ptr - spr_x;
    assign dy   = y_ptr - spr_y;
    assign addr = base + ADDR_W'(dy) * ADDR_W'(spr_w) + ADDR_W'(dx);

endmodule

// File: rtl/sprite_compositor.sv
// Priority compositor of N_SPR sprites over a flat background with ROM-latency-matched
// pipeline and per-frame player collision flags.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned N_SPR   = 8,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                       clk_vga,
    input  logic                       rst_n,
    sprite_compositor_if.slave         pix,
    input  logic [N_SPR-1:0]           spr_en,
    input  logic [N_SPR*COORD_W-1:0]   spr_x,
    input  logic [N_SPR*COORD_W-1:0]   spr_y,
    input  logic [N_SPR*COORD_W-1:0]   spr_w,
    input  logic [N_SPR*COORD_W-1:0]   spr_h,
    input  logic [N_SPR*ADDR_W-1:0]    spr_base,
    output logic [N_SPR-1:0]           collide
);

    localparam int unsigned XW = MAX_SPR * COORD_W;
    localparam int unsigned BW = MAX_SPR * MAX_AW;

    typedef struct packed {
        logic             any;
        spr_idx_t         win;
        logic [N_SPR-1:0] mask;
        logic             valid;
        logic             fs;
    } ctl_t;

    logic [XW-1:0]     x_flat, y_flat, w_flat, h_flat;
    logic [BW-1:0]     base_flat;
    logic [N_SPR-1:0]  hit;
    logic [ADDR_W-1:0] slot_addr [N_SPR];

    assign x_flat    = XW'(spr_x);
    assign y_flat    = XW'(spr_y);
    assign w_flat    = XW'(spr_w);
    assign h_flat    = XW'(spr_h);
    assign base_flat = BW'(spr_base);

    for (genvar i = 0; i < N_SPR; i++) begin : g_slot
        sprite_hit_unit #(
            .ADDR_W(ADDR_W)
        ) u_hit (
            .en        (spr_en[i]),
            .pix_valid (pix.pix_valid),
            .x_ptr     (pix.x_ptr),
            .y_ptr     (pix.y_ptr),
            .spr_x     (get_x(x_flat, i)),
            .spr_y     (get_x(y_flat, i)),
            .spr_w     (get_x(w_flat, i)),
            .spr_h     (get_x(h_flat, i)),
            .base      (ADDR_W'(get_base(base_flat, i, ADDR_W))),
            .hit       (hit[i]),
            .addr      (slot_addr[i])
        );
    end

    spr_idx_t          win;
    logic [ADDR_W-1:0] win_addr;
    logic              any_hit;

    assign any_hit = |hit;

    // Descending scan so the lowest hitting index wins.
    always_comb begin
        win      = '0;
        win_addr = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win      = spr_idx_t'(i);
                win_addr = slot_addr[i];
            end
        end
    end

    logic [ADDR_W-1:0] rom_addr_q;
    ctl_t              pipe_q [ROM_LAT+1];

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            for (int unsigned k = 0; k <= ROM_LAT; k++) pipe_q[k] <= '0;
        end else begin
            if (any_hit) rom_addr_q <= win_addr;
            pipe_q[0] <= '{any: any_hit, win: win, mask: hit,
                           valid: pix.pix_valid, fs: pix.frame_start};
            for (int unsigned k = 1; k <= ROM_LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    ctl_t             o;
    logic             opaque;
    logic [N_SPR-1:0] coll_bits;
    logic [7:0]       rgb_q;
    logic             rgb_valid_q;
    logic [N_SPR-1:0] acc_q;
    logic [N_SPR-1:0] collide_q;

    assign o      = pipe_q[ROM_LAT];
    assign opaque = pix.rom_data != TRANSPARENT;
    // Player (slot 0) opaque pixel over any other slot's box; bit 0 is never set.
    assign coll_bits = (o.any && o.win == '0 && opaque) ? {o.mask[N_SPR-1:1], 1'b0} : '0;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q       <= 8'h00;
            rgb_valid_q <= 1'b0;
            acc_q       <= '0;
            collide_q   <= '0;
        end else begin
            rgb_valid_q <= o.valid;
            if (!o.valid)              rgb_q <= 8'h00;
            else if (o.any && opaque)  rgb_q <= pix.rom_data;
            else                       rgb_q <= BG_COLOR;
            if (o.fs) begin
                collide_q <= acc_q;
                acc_q     <= coll_bits;
            end else begin
                acc_q <= acc_q | coll_bits;
            end
        end
    end

    assign pix.rom_addr  = rom_addr_q;
    assign pix.RGB       = rgb_q;
    assign pix.rgb_valid = rgb_valid_q;
    assign collide       = collide_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: identity ROM models at latency 1 and 3.
module tb_sprite_compositor;
    import sprite_pkg::*;

    localparam int unsigned NS = 8;
    localparam int unsigned AW = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [COORD_W-1:0]    x_ptr = '0, y_ptr = '0;
    logic                  pix_valid = 1'b0, frame_start = 1'b0;
    logic [NS-1:0]         spr_en = '0;
    logic [NS*COORD_W-1:0] spr_x = '0, spr_y = '0, spr_w = '0, spr_h = '0;
    logic [NS*AW-1:0]      spr_base = '0;
    logic [NS-1:0]         collide1, collide3;

    sprite_compositor_if #(.ADDR_W(AW)) if1 ();
    sprite_compositor_if #(.ADDR_W(AW)) if3 ();

    assign if1.x_ptr = x_ptr;       assign if3.x_ptr = x_ptr;
    assign if1.y_ptr = y_ptr;       assign if3.y_ptr = y_ptr;
    assign if1.pix_valid = pix_valid;     assign if3.pix_valid = pix_valid;
    assign if1.frame_start = frame_start; assign if3.frame_start = frame_start;

    // Identity ROM: data = addr[7:0], delayed by the ROM latency.
    logic [7:0] rom1_q;
    logic [7:0] rom3_q [3];
    always @(posedge clk) begin
        rom1_q    <= if1.rom_addr[7:0];
        rom3_q[0] <= if3.rom_addr[7:0];
        rom3_q[1] <= rom3_q[0];
        rom3_q[2] <= rom3_q[1];
    end
    assign if1.rom_data = rom1_q;
    assign if3.rom_data = rom3_q[2];

    sprite_compositor #(.N_SPR(NS), .ADDR_W(AW), .ROM_LAT(1)) dut (
        .clk_vga(clk), .rst_n(rst_n), .pix(if1), .spr_en(spr_en), .spr_x(spr_x),
        .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h), .spr_base(spr_base),
        .collide(collide1)
    );

    sprite_compositor #(.N_SPR(NS), .ADDR_W(AW), .ROM_LAT(3)) dut3 (
        .clk_vga(clk), .rst_n(rst_n), .pix(if3), .spr_en(spr_en), .spr_x(spr_x),
        .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h), .spr_base(spr_base),
        .collide(collide3)
    );

    typedef struct packed { logic [7:0] rgb; logic [7:0] id; } rexp_t;
    typedef struct packed { int due; logic [AW-1:0] addr; logic [7:0] id; } aexp_t;

    rexp_t rq[$];
    aexp_t aq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops address and pixel expectations as the DUT presents them.
    always @(negedge clk) begin
        if (rst_n) begin
            while (aq.size() > 0 && aq[0].due <= cyc) begin
                aexp_t e;
                e = aq.pop_front();
                check($sformatf("rom_addr#%0d", e.id), 32'(if1.rom_addr), 32'(e.addr));
            end
            if (if1.rgb_valid) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rgb_extra: got RGB 0x%0h with no pixel expected", if1.RGB);
                end else begin
                    rexp_t r;
                    r = rq.pop_front();
                    check($sformatf("rgb#%0d", r.id), 32'(if1.RGB), 32'(r.rgb));
                end
            end
        end
    end

    task automatic set_spr(input int i, input logic en, input int x, input int y,
                           input int w, input int h, input int b);
        spr_en[i]                 = en;
        spr_x[i*COORD_W +: COORD_W] = x[COORD_W-1:0];
        spr_y[i*COORD_W +: COORD_W] = y[COORD_W-1:0];
        spr_w[i*COORD_W +: COORD_W] = w[COORD_W-1:0];
        spr_h[i*COORD_W +: COORD_W] = h[COORD_W-1:0];
        spr_base[i*AW +: AW]        = b[AW-1:0];
    endtask

    // One pixel per call; expectations are queued for the monitor.
    task automatic pix(input int x, input int y, input logic v, input logic fs,
                       input int exp_rgb, input logic chk_addr, input int exp_addr,
                       input int id);
        x_ptr       = x[COORD_W-1:0];
        y_ptr       = y[COORD_W-1:0];
        pix_valid   = v;
        frame_start = fs;
        if (v) rq.push_back('{rgb: exp_rgb[7:0], id: id[7:0]});
        if (chk_addr) aq.push_back('{due: cyc + 1, addr: exp_addr[AW-1:0], id: id[7:0]});
        @(posedge clk);
        #1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        pix(0, 0, 1'b0, 1'b1, 0, 1'b0, 0, 0);
        idle(4);
    endtask

    int lat1, lat3;
    logic [7:0] rgb3;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_rgb", 32'(if1.RGB), 32'h0);
        check("rst_rgb_valid", 32'(if1.rgb_valid), 32'h0);
        check("rst_rom_addr", 32'(if1.rom_addr), 32'h0);
        check("rst_collide", 32'(collide1), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Single sprite, identity ROM.
        set_spr(0, 1'b1, 100, 50, 16, 16, 0);
        pix(103, 52, 1'b1, 1'b0, 35, 1'b1, 35, 1);
        pix(115, 65, 1'b1, 1'b0, 0, 1'b1, 255, 2);
        pix(116, 50, 1'b1, 1'b0, 0, 1'b1, 255, 3);
        pix(101, 50, 1'b1, 1'b0, 1, 1'b1, 1, 4);
        pix(103, 52, 1'b0, 1'b0, 0, 1'b1, 1, 5);
        idle(4);
        frame_pulse();
        check("collide_no_overlap", 32'(collide1), 32'h0);

        // Overlap priority: slot 0 wins over slot 2, then slot 2 alone.
        set_spr(0, 1'b1, 196, 96, 16, 16, 'h100);
        set_spr(2, 1'b1, 200, 100, 8, 8, 'h40);
        pix(200, 100, 1'b1, 1'b0, 'h44, 1'b1, 'h144, 7);
        set_spr(0, 1'b0, 196, 96, 16, 16, 'h100);
        pix(200, 100, 1'b1, 1'b0, 'h40, 1'b1, 'h40, 8);
        idle(4);
        frame_pulse();
        check("collide_slot2", 32'(collide1), 32'h04);

        // Transparent winner shows background and does not collide.
        set_spr(0, 1'b1, 196, 96, 16, 16, 'h1BB);
        pix(200, 100, 1'b1, 1'b0, 0, 1'b1, 'h1FF, 10);
        idle(4);
        frame_pulse();
        check("collide_transparent", 32'(collide1), 32'h0);

        // Collision across frames, then a clean frame, then a same-cycle collision.
        set_spr(2, 1'b0, 0, 0, 0, 0, 0);
        set_spr(0, 1'b1, 298, 198, 8, 8, 0);
        set_spr(3, 1'b1, 300, 200, 4, 4, 'h80);
        pix(300, 200, 1'b1, 1'b0, 18, 1'b1, 18, 11);
        idle(4);
        frame_pulse();
        check("collide_slot3", 32'(collide1), 32'h08);
        pix(298, 198, 1'b1, 1'b0, 0, 1'b1, 0, 12);
        idle(4);
        frame_pulse();
        check("collide_cleared", 32'(collide1), 32'h0);
        pix(300, 200, 1'b1, 1'b1, 18, 1'b1, 18, 13);
        idle(4);
        check("collide_same_cycle_old", 32'(collide1), 32'h0);
        frame_pulse();
        check("collide_same_cycle_new", 32'(collide1), 32'h08);

        // Right edge beyond the coordinate range, and zero width.
        set_spr(0, 1'b0, 0, 0, 0, 0, 0);
        set_spr(3, 1'b0, 0, 0, 0, 0, 0);
        set_spr(1, 1'b1, 1015, 0, 16, 4, 'h200);
        pix(1023, 1, 1'b1, 1'b0, 'h18, 1'b1, 'h218, 14);
        pix(0, 1, 1'b1, 1'b0, 0, 1'b1, 'h218, 15);
        set_spr(1, 1'b1, 1015, 0, 0, 4, 'h200);
        pix(1015, 1, 1'b1, 1'b0, 0, 1'b1, 'h218, 16);
        idle(4);

        // Reset during an active hit, then measure restart latency.
        set_spr(1, 1'b0, 0, 0, 0, 0, 0);
        set_spr(0, 1'b1, 100, 50, 16, 16, 0);
        pix(103, 52, 1'b1, 1'b0, 35, 1'b0, 0, 17);
        pix(103, 52, 1'b1, 1'b0, 35, 1'b0, 0, 18);
        pix(103, 52, 1'b1, 1'b0, 35, 1'b0, 0, 19);
        #1 rst_n = 1'b0;
        rq.delete();
        aq.delete();
        #1;
        check("midrst_rgb", 32'(if1.RGB), 32'h0);
        check("midrst_rgb_valid", 32'(if1.rgb_valid), 32'h0);
        check("midrst_collide", 32'(collide1), 32'h0);
        check("midrst_rom_addr", 32'(if1.rom_addr), 32'h0);
        check("midrst_rgb_valid_lat3", 32'(if3.rgb_valid), 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        x_ptr     = 10'd103;
        y_ptr     = 10'd52;
        pix_valid = 1'b1;
        rq.push_back('{rgb: 8'd35, id: 8'd20});
        lat1 = 0;
        lat3 = 0;
        rgb3 = 8'h00;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) pix_valid = 1'b0;
            if (lat1 == 0 && if1.rgb_valid) lat1 = n;
            if (lat3 == 0 && if3.rgb_valid) begin
                lat3 = n;
                rgb3 = if3.RGB;
            end
        end
        check("restart_latency_lat1", 32'(lat1), 32'd3);
        check("restart_latency_lat3", 32'(lat3), 32'd5);
        check("restart_rgb_lat3", 32'(rgb3), 32'd35);

        idle(2);
        check("scoreboard_rgb_drained", 32'(rq.size()), 32'd0);
        check("scoreboard_addr_drained", 32'(aq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the single-cat/pipe/coin display selector.
- Composites N_SPR rectangular sprites over a flat background colour for the VGA pixel stream, with fixed priority (index 0 on top) and a colour-key transparency value.
- Generates addresses into one shared sprite ROM of configurable read latency, with a matched pipeline.
- Latches per-frame collision flags between sprite 0 (player) and every other sprite for the game FSM.

Parameters:
- N_SPR, 8, number of sprite slots (2..16)
- COORD_W, 10, pixel coordinate width
- ADDR_W, 13, shared sprite ROM address width
- ROM_LAT, 1, ROM read latency in cycles (1..3)
- TRANSPARENT, 8'hFF, colour key treated as see-through
- BG_COLOR, 8'h00, colour driven when no opaque sprite pixel

Ports:
- clk_vga  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- x_ptr  in  COORD_W  current pixel column
- y_ptr  in  COORD_W  current pixel row
- pix_valid  in  1  pixel is inside the visible area
- frame_start  in  1  one-cycle pulse at the first pixel of a frame
- spr_en  in  N_SPR  per-slot enable
- spr_x  in  N_SPR*COORD_W  flat left edges
- spr_y  in  N_SPR*COORD_W  flat top edges
- spr_w  in  N_SPR*COORD_W  flat widths (0 = disabled)
- spr_h  in  N_SPR*COORD_W  flat heights (0 = disabled)
- spr_base  in  N_SPR*ADDR_W  flat ROM base address per slot
- rom_addr  out  ADDR_W  shared ROM address
- rom_data  in  8  ROM pixel, valid ROM_LAT cycles after rom_addr
- RGB  out  8  composited pixel
- rgb_valid  out  1  RGB corresponds to a delayed pix_valid
- collide  out  N_SPR  collision flags of the previous frame; bit 0 is always 0

Behaviour:
- Reset (asynchronous, rst_n=0) clears:
  - RGB=8'h00, rgb_valid=0, rom_addr=0, collide=0.
  - All pipeline registers and the sticky collision accumulator.
- Hit test (stage 0, combinational on inputs): hit[i] = spr_en[i] && pix_valid && x_ptr>=x_i && x_ptr<x_i+w_i && y_ptr>=y_i && y_ptr<y_i+h_i.
  - Compares are computed at COORD_W+1 bits so the right/bottom edge never wraps.
  - w=0 or h=0 gives no hit.
- Priority: the winner is the lowest index with hit set; any_hit is the OR of hit.
- Address: rom_addr = base_w + (y_ptr-y_w)*w_w + (x_ptr-x_w), truncated to ADDR_W (wrap is permitted and is the sprite packer's responsibility).
  - Computed from inputs directly, so there is no running counter and no edge-of-sprite reset logic.
- Stage 1 (t+1): register rom_addr; register any_hit, winner index, hit mask and pix_valid.
  - No hit: rom_addr holds its previous value.
- Delay line: carries any_hit, winner, hit mask and pix_valid ROM_LAT further cycles to align with rom_data.
- Output stage (t+2+ROM_LAT):
  - RGB = (any_hit && rom_data!=TRANSPARENT) ? rom_data : BG_COLOR.
  - rgb_valid = delayed pix_valid.
  - When pix_valid=0, RGB is forced to 8'h00.
- Transparency: a transparent pixel of the winning sprite shows BG_COLOR, not the next sprite down. This is the decided single-fetch behaviour.
- Collision, evaluated in the output stage:
  - Condition: delayed winner==0, rom_data!=TRANSPARENT, and delayed hit[j] for j>=1.
  - Action: acc[j] is set to 1.
- frame_start, sampled at input stage and delayed with the pipeline:
  - On its delayed arrival, collide<=acc and acc is cleared.
  - A collision in that same cycle is written into the cleared acc, so it counts toward the new frame.
- No back-pressure: exactly one pixel per clock enters and leaves.
- Parameter changes to sprite positions mid-frame take effect on the next pixel; no shadowing.
- Reset mid-frame discards all in-flight pixels. The first valid output appears 2+ROM_LAT cycles after the first pix_valid following reset release.

Decomposition:
- Shared package sprite_pkg holds:
  - Constants: TRANSPARENT, BG_COLOR, COORD_W.
  - Flat-slice helper functions: get_x(i), get_base(i).
  - Sprite index typedef sized to clog2(N_SPR).
- One sub-module, sprite_hit_unit: a per-slot bounds compare and offset computation, instantiated N_SPR times via generate.
- Priority encoder, delay line and collision accumulator stay in the top module.

Test Plan:
- Single sprite, reset then stimulus:
  - Stimulus: slot 0 at (100,50), 16x16, base 0; identity ROM (data=addr[7:0]), ROM_LAT=1; scan pixel (103,52).
  - Response: rom_addr=35 at t+1; RGB=8'd35 at t+3; rgb_valid=1.
- Overlap priority: slot 0 and slot 2 both cover (200,100) → rom_addr uses slot 0's base; with slot 0 disabled, it uses slot 2's base.
- Transparency: ROM returns 8'hFF for the winning sprite → RGB=BG_COLOR (8'h00); collide is not set.
- Collision across frames:
  - Opaque slot 0 pixel overlaps slot 3 box in frame N → collide=8'b0000_1000 after frame N+1's frame_start reaches the output.
  - No overlap during frame N+1 → collide=0 after frame N+2's frame_start.
- Edges:
  - Sprite at x=1015, w=16 (right edge beyond the 10-bit range): x_ptr=1023 hits; x_ptr=0 does not.
  - w=0 → never hits.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during an active hit.
  - Response: RGB=0, rgb_valid=0, collide=0 immediately (asynchronous); outputs resume 2+ROM_LAT cycles after release.
  - Repeat with ROM_LAT=3 → latency becomes 5.
